// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external async SRAM between video fetch (read-only),
// the CPU and the SD/DMA engine. Each access runs IDLE -> SETUP -> ACCESS (x WAIT_CYCLES)
// -> HOLD. The winner's ack pulses during HOLD, together with read data.
//
// Ports
//   clk_sys, reset_n          system clock, async active-low reset
//   vid_req/addr/ack          video read requester
//   cpu_req/we/addr/wdata/ack CPU requester
//   dma_req/we/addr/wdata/ack SD/DMA requester
//   rdata                     read data, valid with ack, held until the next read ack
//   sram_a, sram_dout         SRAM address and write data
//   sram_oe                   drive sram_dout onto the SRAM data bus
//   sram_din                  SRAM data bus input
//   sram_we_n                 SRAM write enable, active low
//   busy                      access in progress
//   grant                     current owner: 0 none, 1 video, 2 cpu, 3 dma
module sram_arbiter #(
    parameter int unsigned ADDR_W      = 21,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned VID_BURST   = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_oe,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_we_n,
    output logic              busy,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

    localparam logic [1:0] GntNone = 2'd0;
    localparam logic [1:0] GntVid  = 2'd1;
    localparam logic [1:0] GntCpu  = 2'd2;
    localparam logic [1:0] GntDma  = 2'd3;

    localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] VidBurst = 4'(VID_BURST);

    state_e            state;
    logic [3:0]        wait_cnt;
    logic [3:0]        vid_cnt;
    logic              rr_dma;     // 0: CPU wins the next CPU/DMA tie, 1: DMA wins
    logic              wr;         // latched direction of the current access

    logic              others;
    logic [1:0]        win;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_we;

    // Video has priority until it has used up its burst while CPU/DMA wait.
    always_comb begin
        others = cpu_req | dma_req;
        win    = GntNone;
        if (vid_req && !(vid_cnt == VidBurst && others)) begin
            win = GntVid;
        end else if (cpu_req && (!dma_req || !rr_dma)) begin
            win = GntCpu;
        end else if (dma_req) begin
            win = GntDma;
        end
    end

    always_comb begin
        win_addr  = vid_addr;
        win_wdata = '0;
        win_we    = 1'b0;
        case (win)
            GntCpu: begin
                win_addr  = cpu_addr;
                win_wdata = cpu_wdata;
                win_we    = cpu_we;
            end
            GntDma: begin
                win_addr  = dma_addr;
                win_wdata = dma_wdata;
                win_we    = dma_we;
            end
            default: ;
        endcase
    end

    assign busy = (state != StIdle);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StIdle;
            wait_cnt  <= '0;
            vid_cnt   <= '0;
            rr_dma    <= 1'b0;
            wr        <= 1'b0;
            sram_a    <= '0;
            sram_dout <= '0;
            sram_oe   <= 1'b0;
            sram_we_n <= 1'b1;
            rdata     <= '0;
            vid_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            grant     <= GntNone;
        end else begin
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                StIdle: begin
                    grant <= win;
                    if (win != GntNone) begin
                        state     <= StSetup;
                        sram_a    <= win_addr;
                        sram_dout <= win_wdata;
                        wr        <= win_we;
                        sram_oe   <= win_we;
                        if (win == GntVid) begin
                            // Count only grants that made someone else wait.
                            if (!others) begin
                                vid_cnt <= '0;
                            end else if (vid_cnt != VidBurst) begin
                                vid_cnt <= vid_cnt + 4'd1;
                            end
                        end else begin
                            vid_cnt <= '0;
                            rr_dma  <= (win == GntCpu);
                        end
                    end
                end
                StSetup: begin
                    state     <= StAccess;
                    wait_cnt  <= '0;
                    sram_we_n <= ~wr;
                end
                StAccess: begin
                    if (wait_cnt == WaitLast) begin
                        state     <= StHold;
                        sram_we_n <= 1'b1;
                        if (!wr) begin
                            rdata <= sram_din;
                        end
                        vid_ack <= (grant == GntVid);
                        cpu_ack <= (grant == GntCpu);
                        dma_ack <= (grant == GntDma);
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                StHold: begin
                    state   <= StIdle;
                    sram_oe <= 1'b0;
                    grant   <= GntNone;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
